// File: rtl/tmr_multi.sv
// Multi-channel down-counting system timer behind a one-wait-state bus slave.
// Each channel: periodic/one-shot, run bit, sticky expiry flag, maskable irq.
module tmr_multi #(
  parameter int NCH   = 4,
  parameter int CNT_W = 32,
  parameter int CH_W  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              wr,
  input  logic [CH_W+1:0]   addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              wt,
  output logic [NCH-1:0]    irq
);

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_DIV  = 2'd1;
  localparam logic [1:0] REG_CNT  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  function automatic logic [31:0] zext_cnt(input logic [CNT_W-1:0] v);
    logic [31:0] r;
    r = '0;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  logic              ack_q, ack_d;
  logic [31:0]       dout_q, dout_d;
  logic [NCH-1:0]    irq_q, irq_d;

  logic [CNT_W-1:0]  cnt_q [NCH];
  logic [CNT_W-1:0]  cnt_d [NCH];
  logic [CNT_W-1:0]  div_q [NCH];
  logic [CNT_W-1:0]  div_d [NCH];
  logic [NCH-1:0]    exp_q, exp_d;
  logic [NCH-1:0]    ien_q, ien_d;
  logic [NCH-1:0]    one_q, one_d;
  logic [NCH-1:0]    run_q, run_d;

  logic [1:0]        reg_sel;
  logic [CH_W-1:0]   ch_sel;
  logic              acc_first;
  logic              we;
  logic [NCH-1:0]    wr_ctrl, wr_div, tick, expire;
  logic [31:0]       stat;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign reg_sel   = addr[1:0];
  assign ch_sel    = addr[CH_W+1:2];
  // The first cycle of an access is the only one that commits or samples.
  assign acc_first = en & ~ack_q;
  assign we        = acc_first & wr;
  assign wt        = en & ~ack_q & reset_n;
  assign data_out  = dout_q;
  assign irq       = irq_q;
  assign unused_bits = ^data_in;

  always_comb begin
    wr_ctrl = '0;
    wr_div  = '0;
    tick    = '0;
    expire  = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_ctrl[i] = we && (ch_sel == CH_W'(i)) && (reg_sel == REG_CTRL);
      wr_div[i]  = we && (ch_sel == CH_W'(i)) && (reg_sel == REG_DIV);
      tick[i]    = run_q[i] && (div_q[i] != '0);
      expire[i]  = tick[i] && (cnt_q[i] == CNT_W'(1));
    end
  end

  // Hardware expiry overrides a software clear of EXP in the same edge.
  always_comb begin
    exp_d = exp_q;
    ien_d = ien_q;
    one_d = one_q;
    run_d = run_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      div_d[i] = div_q[i];
      if (wr_ctrl[i]) begin
        exp_d[i] = exp_q[i] & data_in[0];
        ien_d[i] = data_in[1];
        one_d[i] = data_in[2];
        run_d[i] = data_in[3];
      end
      if (expire[i]) begin
        exp_d[i] = 1'b1;
        if (one_q[i]) begin
          run_d[i] = 1'b0;
        end
      end
      if (wr_div[i]) begin
        div_d[i] = data_in[CNT_W-1:0];
        cnt_d[i] = data_in[CNT_W-1:0];
      end else if (tick[i]) begin
        // A zero count with a live divisor (after a mode change) just reloads.
        cnt_d[i] = (cnt_q[i] <= CNT_W'(1)) ? div_q[i] : cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    stat = '0;
    stat[NCH-1:0] = exp_q;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        case (reg_sel)
          REG_CTRL: rdata = {28'b0, run_q[i], one_q[i], ien_q[i], exp_q[i]};
          REG_DIV:  rdata = zext_cnt(div_q[i]);
          REG_CNT:  rdata = zext_cnt(cnt_q[i]);
          REG_STAT: rdata = stat;
          default:  rdata = '0;
        endcase
      end
    end
  end

  always_comb begin
    ack_d  = acc_first;
    dout_d = (acc_first && !wr) ? rdata : dout_q;
    irq_d  = exp_q & ien_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q  <= 1'b0;
      dout_q <= '0;
      irq_q  <= '0;
      exp_q  <= '0;
      ien_q  <= '0;
      one_q  <= '0;
      run_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= '0;
      end
    end else begin
      ack_q  <= ack_d;
      dout_q <= dout_d;
      irq_q  <= irq_d;
      exp_q  <= exp_d;
      ien_q  <= ien_d;
      one_q  <= one_d;
      run_q  <= run_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
    end
  end

endmodule

// File: tb/tb_tmr_multi.sv
// Directed bench for tmr_multi: a 4-channel/32-bit instance (A) and a
// 3-channel/16-bit instance (B) sharing clock and reset.
module tb_tmr_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  always #5 clk = ~clk;

  logic        en_a, wr_a, wt_a;
  logic [3:0]  addr_a;
  logic [31:0] din_a, dout_a;
  logic [3:0]  irq_a;

  logic        en_b, wr_b, wt_b;
  logic [3:0]  addr_b;
  logic [31:0] din_b, dout_b;
  logic [2:0]  irq_b;

  tmr_multi #(.NCH(4), .CNT_W(32), .CH_W(2)) u_a (
    .clk(clk), .reset_n(reset_n), .en(en_a), .wr(wr_a), .addr(addr_a),
    .data_in(din_a), .data_out(dout_a), .wt(wt_a), .irq(irq_a)
  );

  tmr_multi #(.NCH(3), .CNT_W(16), .CH_W(2)) u_b (
    .clk(clk), .reset_n(reset_n), .en(en_b), .wr(wr_b), .addr(addr_b),
    .data_in(din_b), .data_out(dout_b), .wt(wt_b), .irq(irq_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          s;
    bit          w;
    int          ch;
    int          rg;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus access; starts at the next falling edge, returns at the falling edge where wt=0.
  task automatic access(input bit s, input bit w, input int ch, input int rg,
                        input logic [31:0] wd, output logic [31:0] rd);
    int waits;
    logic [3:0] a;
    a = {ch[1:0], rg[1:0]};
    @(negedge clk);
    if (!s) begin
      en_a = 1'b1; wr_a = w; addr_a = a; din_a = wd;
    end else begin
      en_b = 1'b1; wr_b = w; addr_b = a; din_b = wd;
    end
    #1;
    waits = 0;
    while ((s ? wt_b : wt_a) && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    check($sformatf("wait_cycles dut%0d ch%0d r%0d", s, ch, rg), waits, 1);
    rd = s ? dout_b : dout_a;
    en_a = 1'b0;
    en_b = 1'b0;
  endtask

  task automatic wr_reg(input bit s, input int ch, input int rg, input logic [31:0] d);
    logic [31:0] dummy;
    access(s, 1'b1, ch, rg, d, dummy);
  endtask

  task automatic rd_chk(input string name, input bit s, input int ch, input int rg,
                        input logic [31:0] req);
    logic [31:0] rd;
    access(s, 1'b0, ch, rg, 32'h0, rd);
    check(name, rd, req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    reset_n = 1'b0;
    en_a = 1'b0; wr_a = 1'b0; addr_a = '0; din_a = '0;
    en_b = 1'b0; wr_b = 1'b0; addr_b = '0; din_b = '0;

    tbl.push_back('{1'b0, 1'b0, 0, 0, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1, 1, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 2, 2, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 3, 3, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 2, 1, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 2, 1, 32'h1234, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 2, 1, 32'h0, 32'h1234});
    tbl.push_back('{1'b0, 1'b0, 2, 2, 32'h0, 32'h1234});
    tbl.push_back('{1'b0, 1'b1, 2, 2, 32'hFFFF, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 2, 2, 32'h0, 32'h1234});
    tbl.push_back('{1'b0, 1'b1, 2, 0, 32'hFFFFFFF6, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 2, 0, 32'h0, 32'h6});
    tbl.push_back('{1'b0, 1'b1, 2, 0, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 2, 0, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 0, 1, 32'hABCD1234, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 0, 1, 32'h0, 32'hABCD1234});
    tbl.push_back('{1'b0, 1'b1, 2, 3, 32'hF, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 2, 3, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 1, 1, 32'hABCD1234, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1, 1, 32'h0, 32'h1234});
    tbl.push_back('{1'b1, 1'b0, 1, 2, 32'h0, 32'h1234});
    tbl.push_back('{1'b1, 1'b1, 3, 1, 32'h55, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3, 1, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3, 0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1, 0, 32'h0, 32'h0});

    tick(2);
    check("reset_wt",   {31'b0, wt_a}, 32'h0);
    check("reset_irq",  {28'b0, irq_a}, 32'h0);
    check("reset_dout", dout_a, 32'h0);
    reset_n = 1'b1;
    tick(1);

    for (int i = 0; i < tbl.size(); i++) begin
      access(tbl[i].s, tbl[i].w, tbl[i].ch, tbl[i].rg, tbl[i].d, rd);
      if (!tbl[i].w)
        check($sformatf("tbl[%0d] dut%0d ch%0d r%0d", i, tbl[i].s, tbl[i].ch, tbl[i].rg),
              rd, tbl[i].exp);
    end

    // Periodic channel 1, divisor 5.
    wr_reg(1'b0, 1, 1, 32'd5);
    wr_reg(1'b0, 1, 0, 32'hA);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("periodic_irq1 k%0d", k), {31'b0, irq_a[1]}, (k >= 6) ? 32'h1 : 32'h0);
    end
    rd_chk("periodic_cnt_a", 1'b0, 1, 2, 32'd3);
    rd_chk("periodic_cnt_b", 1'b0, 1, 2, 32'd1);
    rd_chk("periodic_cnt_c", 1'b0, 1, 2, 32'd4);
    wr_reg(1'b0, 1, 0, 32'h0);

    // One-shot channel 0, divisor 3.
    wr_reg(1'b0, 0, 1, 32'd3);
    wr_reg(1'b0, 0, 0, 32'hC);
    rd_chk("oneshot_cnt_early", 1'b0, 0, 2, 32'd2);
    tick(20);
    rd_chk("oneshot_ctrl", 1'b0, 0, 0, 32'h5);
    rd_chk("oneshot_cnt_hold", 1'b0, 0, 2, 32'd3);
    check("oneshot_irq0_masked", {31'b0, irq_a[0]}, 32'h0);
    wr_reg(1'b0, 0, 0, 32'h0);

    // Channel 3: CTRL write clearing EXP lands on the expiry edge.
    wr_reg(1'b0, 3, 1, 32'd4);
    wr_reg(1'b0, 3, 0, 32'hA);
    tick(2);
    wr_reg(1'b0, 3, 0, 32'hA);
    tick(1);
    check("race_irq_vec", {28'b0, irq_a}, 32'h8);
    rd_chk("race_ctrl", 1'b0, 3, 0, 32'hB);
    check("race_irq3_held", {31'b0, irq_a[3]}, 32'h1);
    wr_reg(1'b0, 3, 0, 32'h2);
    check("clear_irq3_same", {31'b0, irq_a[3]}, 32'h1);
    tick(1);
    check("clear_irq3_next", {31'b0, irq_a[3]}, 32'h0);
    rd_chk("clear_ctrl", 1'b0, 3, 0, 32'h2);

    // STAT on the 3-channel instance with channels 0 and 2 expired.
    wr_reg(1'b1, 0, 1, 32'd2);
    wr_reg(1'b1, 0, 0, 32'h8);
    wr_reg(1'b1, 2, 1, 32'd3);
    wr_reg(1'b1, 2, 0, 32'hC);
    tick(10);
    rd_chk("stat_ch0", 1'b1, 0, 3, 32'h5);
    rd_chk("stat_ch1", 1'b1, 1, 3, 32'h5);
    rd_chk("stat_ch2", 1'b1, 2, 3, 32'h5);
    rd_chk("b_ch0_ctrl", 1'b1, 0, 0, 32'h9);

    // Asynchronous reset in the middle of a write, with a channel counting.
    wr_reg(1'b0, 1, 1, 32'd3);
    wr_reg(1'b0, 1, 0, 32'hA);
    rd_chk("pre_reset_ctrl", 1'b0, 1, 0, 32'hA);
    tick(3);
    check("pre_reset_irq", {28'b0, irq_a}, 32'h2);
    en_a = 1'b1; wr_a = 1'b1; addr_a = {2'd1, 2'd1}; din_a = 32'h99;
    #1;
    check("midacc_wt_high", {31'b0, wt_a}, 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_wt",   {31'b0, wt_a}, 32'h0);
    check("async_irq",  {28'b0, irq_a}, 32'h0);
    check("async_dout", dout_a, 32'h0);
    en_a = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("post_reset_ctrl", 1'b0, 1, 0, 32'h0);
    rd_chk("post_reset_cnt",  1'b0, 1, 2, 32'h0);
    rd_chk("post_reset_div",  1'b0, 1, 1, 32'h0);
    rd_chk("post_reset_stat", 1'b0, 0, 3, 32'h0);
    rd_chk("post_reset_b",    1'b1, 0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
